// File: rtl/exmem_if.sv
// EX -> MEM pipeline bundle: execute-stage inputs and memory-stage outputs of exmem_reg.
// The "slave" modport is the pipeline register; the "master" modport is the EX/MEM environment around it.
interface exmem_if #(
    parameter int DW = 64,
    parameter int AW = 32
);
    logic          flush_i;
    logic          Mem_StallReq;
    logic          IDEX_Valid;
    logic          EX_StallReq;
    logic [DW-1:0] EX_AluData;
    logic [DW-1:0] IDEX_Rs2Data;
    logic [4:0]    IDEX_RdAddr;
    logic          IDEX_RegWrite;
    logic [2:0]    IDEX_LdType;
    logic [1:0]    IDEX_StType;
    logic [AW-1:0] IDEX_NowPC;
    logic          EX_BranchFlag;
    logic [AW-1:0] EX_BranchPC;
    logic [4:0]    EX_FpuException;
    logic          EX_FpuReady;

    logic          EXMEM_Valid;
    logic [DW-1:0] EXMEM_AluData;
    logic [31:0]   EXMEM_StData;
    logic [3:0]    EXMEM_ByteEn;
    logic [4:0]    EXMEM_RdAddr;
    logic          EXMEM_RegWrite;
    logic [2:0]    EXMEM_LdType;
    logic [1:0]    EXMEM_StType;
    logic [AW-1:0] EXMEM_NowPC;
    logic          EXMEM_Misalign;
    logic [4:0]    EXMEM_Fflags;
    logic          EXMEM_FflagsWe;
    logic          Redirect_Valid;
    logic [AW-1:0] Redirect_PC;

    modport master (
        output flush_i, Mem_StallReq, IDEX_Valid, EX_StallReq, EX_AluData, IDEX_Rs2Data,
               IDEX_RdAddr, IDEX_RegWrite, IDEX_LdType, IDEX_StType, IDEX_NowPC,
               EX_BranchFlag, EX_BranchPC, EX_FpuException, EX_FpuReady,
        input  EXMEM_Valid, EXMEM_AluData, EXMEM_StData, EXMEM_ByteEn, EXMEM_RdAddr,
               EXMEM_RegWrite, EXMEM_LdType, EXMEM_StType, EXMEM_NowPC, EXMEM_Misalign,
               EXMEM_Fflags, EXMEM_FflagsWe, Redirect_Valid, Redirect_PC
    );

    modport slave (
        input  flush_i, Mem_StallReq, IDEX_Valid, EX_StallReq, EX_AluData, IDEX_Rs2Data,
               IDEX_RdAddr, IDEX_RegWrite, IDEX_LdType, IDEX_StType, IDEX_NowPC,
               EX_BranchFlag, EX_BranchPC, EX_FpuException, EX_FpuReady,
        output EXMEM_Valid, EXMEM_AluData, EXMEM_StData, EXMEM_ByteEn, EXMEM_RdAddr,
               EXMEM_RegWrite, EXMEM_LdType, EXMEM_StType, EXMEM_NowPC, EXMEM_Misalign,
               EXMEM_Fflags, EXMEM_FflagsWe, Redirect_Valid, Redirect_PC
    );
endinterface

// File: rtl/exmem_reg.sv
// EX/MEM pipeline register: captures the leaving EX instruction, aligns store data,
// flags misaligned accesses and issues a one-cycle registered fetch redirect.
module exmem_reg #(
    parameter int DW = 64,
    parameter int AW = 32
) (
    input logic   clk,
    input logic   rst_n,
    exmem_if.slave bus
);
    typedef enum logic [2:0] {LD_NONE, LD_B, LD_H, LD_W, LD_BU, LD_HU} ld_e;
    typedef enum logic [1:0] {ST_NONE, ST_B, ST_H, ST_W} st_e;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] alu_data;
        logic [31:0]   st_data;
        logic [3:0]    byte_en;
        logic [4:0]    rd_addr;
        logic          reg_write;
        logic [2:0]    ld_type;
        logic [1:0]    st_type;
        logic [AW-1:0] now_pc;
        logic          misalign;
        logic [4:0]    fflags;
        logic          fflags_we;
        logic          redir_valid;
        logic [AW-1:0] redir_pc;
    } exmem_t;

    exmem_t      r_q;
    exmem_t      w_d;
    logic [1:0]  w_a;
    logic [31:0] w_st_data;
    logic [3:0]  w_byte_en;
    logic        w_misalign;
    logic        w_unused_rs2_hi;

    assign w_a             = bus.EX_AluData[1:0];
    assign w_unused_rs2_hi = ^bus.IDEX_Rs2Data[DW-1:32];

    // Bubbles clear control only; data fields keep their old value so they stay deterministic.
    function automatic exmem_t bubble(input exmem_t q);
        exmem_t b;
        b             = q;
        b.valid       = 1'b0;
        b.reg_write   = 1'b0;
        b.fflags_we   = 1'b0;
        b.misalign    = 1'b0;
        b.redir_valid = 1'b0;
        b.ld_type     = '0;
        b.st_type     = '0;
        b.byte_en     = '0;
        return b;
    endfunction

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_st_data  = bus.IDEX_Rs2Data[31:0];
        w_byte_en  = 4'b0000;
        w_misalign = 1'b0;
        case (st_e'(bus.IDEX_StType))
            ST_B: begin
                w_st_data = {4{bus.IDEX_Rs2Data[7:0]}};
                w_byte_en = 4'b0001 << w_a;
            end
            ST_H: begin
                w_st_data  = {2{bus.IDEX_Rs2Data[15:0]}};
                w_byte_en  = w_a[1] ? 4'b1100 : 4'b0011;
                w_misalign = w_a[0];
            end
            ST_W: begin
                w_byte_en  = 4'b1111;
                w_misalign = (w_a != 2'b00);
            end
            default: ;
        endcase
        case (ld_e'(bus.IDEX_LdType))
            LD_H, LD_HU: if (w_a[0])         w_misalign = 1'b1;
            LD_W:        if (w_a != 2'b00)   w_misalign = 1'b1;
            default: ;
        endcase
        if (w_misalign) w_byte_en = 4'b0000;
    end

    always_comb begin
        w_d = r_q;
        if (bus.flush_i) begin
            w_d = bubble(r_q);
        end else if (bus.Mem_StallReq) begin
            // Hold everything, but a redirect already issued must not repeat.
            w_d.redir_valid = 1'b0;
        end else if (bus.EX_StallReq || !bus.IDEX_Valid) begin
            w_d = bubble(r_q);
        end else begin
            w_d.valid       = 1'b1;
            w_d.alu_data    = bus.EX_AluData;
            w_d.st_data     = w_st_data;
            w_d.byte_en     = w_byte_en;
            w_d.rd_addr     = bus.IDEX_RdAddr;
            w_d.reg_write   = bus.IDEX_RegWrite && !w_misalign;
            w_d.ld_type     = bus.IDEX_LdType;
            w_d.st_type     = bus.IDEX_StType;
            w_d.now_pc      = bus.IDEX_NowPC;
            w_d.misalign    = w_misalign;
            w_d.fflags      = bus.EX_FpuReady ? bus.EX_FpuException : 5'b00000;
            w_d.fflags_we   = bus.EX_FpuReady;
            w_d.redir_valid = bus.EX_BranchFlag;
            w_d.redir_pc    = bus.EX_BranchPC;
        end
    end

    // NOTE: rst_n is asserted high here; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_q <= '0;
        else       r_q <= w_d;
    end

    assign bus.EXMEM_Valid    = r_q.valid;
    assign bus.EXMEM_AluData  = r_q.alu_data;
    assign bus.EXMEM_StData   = r_q.st_data;
    assign bus.EXMEM_ByteEn   = r_q.byte_en;
    assign bus.EXMEM_RdAddr   = r_q.rd_addr;
    assign bus.EXMEM_RegWrite = r_q.reg_write;
    assign bus.EXMEM_LdType   = r_q.ld_type;
    assign bus.EXMEM_StType   = r_q.st_type;
    assign bus.EXMEM_NowPC    = r_q.now_pc;
    assign bus.EXMEM_Misalign = r_q.misalign;
    assign bus.EXMEM_Fflags   = r_q.fflags;
    assign bus.EXMEM_FflagsWe = r_q.fflags_we;
    assign bus.Redirect_Valid = r_q.redir_valid;
    assign bus.Redirect_PC    = r_q.redir_pc;
endmodule

// File: tb/tb_exmem_reg.sv
// Scoreboard bench for exmem_reg: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares one entry per elapsed clock.
module tb_exmem_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    exmem_if #(.DW(64), .AW(32)) bus ();
    exmem_reg #(.DW(64), .AW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid, ex_stall, mem_stall, flush;
        logic [63:0] alu, rs2;
        logic [4:0]  rd;
        logic        rw;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] pc;
        logic        bflag;
        logic [31:0] bpc;
        logic [4:0]  fpe;
        logic        fpr;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] alu;
        logic [31:0] st;
        logic [3:0]  be;
        logic [4:0]  rd;
        logic        rw;
        logic [2:0]  ld;
        logic [1:0]  stt;
        logic [31:0] pc;
        logic        mis;
        logic [4:0]  ff;
        logic        ffwe;
        logic        rv;
        logic [31:0] rpc;
    } out_t;

    typedef struct {
        string name;
        out_t  o;
        bit    full;
        time   t;
    } exp_t;

    exp_t exp_q[$];
    time  last_pos = 0;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic in_t instr(input logic [63:0] alu, input logic [63:0] rs2, input logic [4:0] rd,
                                  input logic rw, input logic [2:0] ld, input logic [1:0] st,
                                  input logic [31:0] pc);
        in_t v = '0;
        v.valid = 1'b1; v.alu = alu; v.rs2 = rs2; v.rd = rd; v.rw = rw;
        v.ld = ld; v.st = st; v.pc = pc;
        return v;
    endfunction

    // Pass-through fields of an advanced instruction; alignment results are set per vector.
    function automatic out_t adv(input in_t v);
        out_t o = '0;
        o.valid = 1'b1; o.alu = v.alu; o.st = v.rs2[31:0]; o.rd = v.rd; o.rw = v.rw;
        o.ld = v.ld; o.stt = v.st; o.pc = v.pc; o.rv = v.bflag; o.rpc = v.bpc;
        return o;
    endfunction

    function automatic out_t ctrl(input out_t o);
        out_t m = o;
        m.alu = '0; m.st = '0; m.rd = '0; m.pc = '0; m.ff = '0; m.rpc = '0;
        return m;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.valid = bus.EXMEM_Valid;    o.alu = bus.EXMEM_AluData;  o.st = bus.EXMEM_StData;
        o.be    = bus.EXMEM_ByteEn;   o.rd  = bus.EXMEM_RdAddr;   o.rw = bus.EXMEM_RegWrite;
        o.ld    = bus.EXMEM_LdType;   o.stt = bus.EXMEM_StType;   o.pc = bus.EXMEM_NowPC;
        o.mis   = bus.EXMEM_Misalign; o.ff  = bus.EXMEM_Fflags;   o.ffwe = bus.EXMEM_FflagsWe;
        o.rv    = bus.Redirect_Valid; o.rpc = bus.Redirect_PC;
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("v=%b alu=%h st=%h be=%b rd=%0d rw=%b ld=%0d stt=%0d pc=%h mis=%b ff=%b ffwe=%b rv=%b rpc=%h",
                         o.valid, o.alu, o.st, o.be, o.rd, o.rw, o.ld, o.stt, o.pc, o.mis, o.ff, o.ffwe, o.rv, o.rpc);
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp, input bit full);
        bit ok;
        n_vec++;
        ok = full ? (act == exp) : (ctrl(act) == ctrl(exp));
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic drive(input in_t v);
        bus.IDEX_Valid = v.valid;   bus.EX_StallReq = v.ex_stall; bus.Mem_StallReq = v.mem_stall;
        bus.flush_i = v.flush;      bus.EX_AluData = v.alu;       bus.IDEX_Rs2Data = v.rs2;
        bus.IDEX_RdAddr = v.rd;     bus.IDEX_RegWrite = v.rw;     bus.IDEX_LdType = v.ld;
        bus.IDEX_StType = v.st;     bus.IDEX_NowPC = v.pc;        bus.EX_BranchFlag = v.bflag;
        bus.EX_BranchPC = v.bpc;    bus.EX_FpuException = v.fpe;  bus.EX_FpuReady = v.fpr;
    endtask

    task automatic apply(input string name, input in_t v, input out_t e, input bit full);
        exp_t x;
        drive(v);
        x.name = name; x.o = e; x.full = full; x.t = $time;
        exp_q.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(posedge clk) last_pos = $time;

    always @(negedge clk) begin
        if (!rst_n && exp_q.size() != 0 && exp_q[0].t < last_pos) begin
            exp_t x;
            x = exp_q.pop_front();
            check(x.name, sample(), x.o, x.full);
        end
    end

    initial begin
        in_t  v, v2;
        out_t e, held;
        drive('0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;

        v = instr(64'h1234, 64'h0, 5'd5, 1'b1, 3'd0, 2'd0, 32'h100);
        e = adv(v); apply("add", v, e, 1);

        v = instr(64'h1003, 64'hAB, 5'd0, 1'b0, 3'd0, 2'd1, 32'h104);
        e = adv(v); e.st = 32'hABABABAB; e.be = 4'b1000; apply("sb_1003", v, e, 1);

        v = instr(64'h1000, 64'hFFFF_0000_0000_005A, 5'd0, 1'b0, 3'd0, 2'd1, 32'h108);
        e = adv(v); e.st = 32'h5A5A5A5A; e.be = 4'b0001; apply("sb_1000", v, e, 1);

        v = instr(64'h1002, 64'hBEEF, 5'd0, 1'b0, 3'd0, 2'd2, 32'h10C);
        e = adv(v); e.st = 32'hBEEFBEEF; e.be = 4'b1100; apply("sh_1002", v, e, 1);

        v = instr(64'h1000, 64'h1234_5678, 5'd0, 1'b0, 3'd0, 2'd2, 32'h110);
        e = adv(v); e.st = 32'h56785678; e.be = 4'b0011; apply("sh_1000", v, e, 1);

        v = instr(64'h1001, 64'h1122_3344, 5'd0, 1'b0, 3'd0, 2'd3, 32'h114);
        e = adv(v); e.st = 32'h11223344; e.be = 4'b0000; e.mis = 1'b1; apply("sw_misalign", v, e, 1);

        v = instr(64'h1000, 64'hCAFE_F00D, 5'd0, 1'b0, 3'd0, 2'd3, 32'h118);
        e = adv(v); e.st = 32'hCAFEF00D; e.be = 4'b1111; apply("sw_aligned", v, e, 1);

        v = instr(64'h1002, 64'h0, 5'd7, 1'b1, 3'd3, 2'd0, 32'h11C);
        e = adv(v); e.mis = 1'b1; e.rw = 1'b0; apply("lw_misalign", v, e, 1);

        v = instr(64'h1001, 64'h0, 5'd8, 1'b1, 3'd2, 2'd0, 32'h120);
        e = adv(v); e.mis = 1'b1; e.rw = 1'b0; apply("lh_misalign", v, e, 1);

        v = instr(64'h1002, 64'h0, 5'd8, 1'b1, 3'd5, 2'd0, 32'h124);
        e = adv(v); apply("lhu_aligned", v, e, 1);

        v = instr(64'h1003, 64'h0, 5'd9, 1'b1, 3'd4, 2'd0, 32'h128);
        e = adv(v); apply("lbu_any", v, e, 1);

        v = instr(64'h4444, 64'h0, 5'd4, 1'b1, 3'd0, 2'd3, 32'h12C);
        v.valid = 1'b0;
        apply("idle_bubble", v, '0, 0);

        v = instr(64'h55, 64'h0, 5'd9, 1'b1, 3'd0, 2'd0, 32'h130);
        v.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) apply("ex_stall_bubble", v, '0, 0);
        v.ex_stall = 1'b0;
        e = adv(v); apply("ex_stall_release", v, e, 1);

        v = instr(64'h77, 64'h0, 5'd3, 1'b1, 3'd0, 2'd0, 32'h1F0);
        v.bflag = 1'b1; v.bpc = 32'h200;
        e = adv(v); apply("branch", v, e, 1);
        held = e; held.rv = 1'b0;
        v2 = instr(64'h99, 64'h0, 5'd6, 1'b1, 3'd0, 2'd0, 32'h1F4);
        v2.mem_stall = 1'b1; v2.bflag = 1'b1; v2.bpc = 32'h300;
        apply("mem_hold_1", v2, held, 1);
        apply("mem_hold_2", v2, held, 1);
        v2.mem_stall = 1'b0;
        e = adv(v2); apply("after_hold", v2, e, 1);

        v = instr(64'h2000, 64'h1234_5678, 5'd0, 1'b0, 3'd0, 2'd3, 32'h1F8);
        v.flush = 1'b1; v.mem_stall = 1'b1; v.bflag = 1'b1; v.bpc = 32'h400;
        apply("flush_priority", v, '0, 0);

        v = instr(64'h3F80_0000, 64'h0, 5'd10, 1'b1, 3'd0, 2'd0, 32'h200);
        v.fpr = 1'b1; v.fpe = 5'b00001;
        e = adv(v); e.ff = 5'b00001; e.ffwe = 1'b1; apply("fpu_ready", v, e, 1);
        v = instr(64'h4000_0000, 64'h0, 5'd11, 1'b1, 3'd0, 2'd0, 32'h204);
        v.fpr = 1'b0; v.fpe = 5'b11111;
        e = adv(v); apply("fpu_not_ready", v, e, 1);

        v.mem_stall = 1'b1;
        drive(v);
        drain();

        @(posedge clk); #2;
        rst_n = 1'b1;
        #1 check("async_reset", sample(), '0, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;

        v = instr(64'h1234, 64'h0, 5'd5, 1'b1, 3'd0, 2'd0, 32'h100);
        e = adv(v); apply("add_after_reset", v, e, 1);
        drive('0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/exmem_reg.md
# exmem_reg

EX/MEM pipeline register for the NF5 core. It sits directly downstream of the execute stage. It captures the ALU/FPU result, store data and control of the instruction leaving EX, and presents them to the memory stage. It also performs store-data lane alignment with byte-enable generation and misalignment detection, and issues a registered one-cycle front-end redirect for taken/mispredicted branches. It inserts bubbles on EX multicycle stalls, holds on memory stalls, and clears on flush.

## Interface
Parameters:
- DW, 64, data width (equals `SIMD_DATA_WIDTH`)
- AW, 32, address/PC width (equals `ADDR_WIDTH`)

Ports:
- clk  in  1  clock; all state rises on posedge
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1, despite the suffix)
- flush_i  in  1  trap/exception flush from commit
- Mem_StallReq  in  1  memory stage cannot accept
- IDEX_Valid  in  1  instruction present in EX
- EX_StallReq  in  1  EX multicycle busy (div/FPU)
- EX_AluData  in  DW  execute result; [31:0] is the effective address for loads/stores
- IDEX_Rs2Data  in  DW  raw store data
- IDEX_RdAddr  in  5  destination register
- IDEX_RegWrite  in  1  destination write enable
- IDEX_LdType  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
- IDEX_StType  in  2  0 none, 1 SB, 2 SH, 3 SW
- IDEX_NowPC  in  AW  PC of the EX instruction
- EX_BranchFlag, EX_BranchPC  in  1, AW  redirect request and target from EX
- EX_FpuException  in  5  FPU flags {NV,DZ,OF,UF,NX}
- EX_FpuReady  in  1  FPU result valid this cycle
- EXMEM_Valid  out  1  instruction present in MEM
- EXMEM_AluData  out  DW  captured result
- EXMEM_StData  out  32  lane-replicated store data
- EXMEM_ByteEn  out  4  store byte enables
- EXMEM_RdAddr, EXMEM_RegWrite  out  5, 1
- EXMEM_LdType, EXMEM_StType  out  3, 2
- EXMEM_NowPC  out  AW
- EXMEM_Misalign  out  1  misaligned load/store captured
- EXMEM_Fflags, EXMEM_FflagsWe  out  5, 1  fflags update for CSR
- Redirect_Valid, Redirect_PC  out  1, AW  one-cycle fetch redirect

## Operation
Update priority per cycle, highest first:
- rst_n=1: async clear.
- flush_i=1: bubble.
- Mem_StallReq=1: hold all registers. Redirect_Valid forced 0.
- EX_StallReq=1 or IDEX_Valid=0: bubble.
- Otherwise: advance, capturing the EX instruction.

Bubble:
- EXMEM_Valid, RegWrite, FflagsWe, Misalign, Redirect_Valid = 0.
- LdType/StType = 0, ByteEn = 0.
- Data fields are don't-care but must be deterministic; hold them.

Advance, with a = EX_AluData[1:0]:
- SB: StData = {4{rs2[7:0]}}, ByteEn = 1<<a.
- SH: StData = {2{rs2[15:0]}}, ByteEn = a[1] ? 4'b1100 : 4'b0011. Misaligned if a[0]=1.
- SW: StData = rs2[31:0], ByteEn = 4'b1111. Misaligned if a≠0.
- LH/LHU: misaligned if a[0]=1.
- LW: misaligned if a≠0.
- LB/LBU/none: never misaligned.
- Misaligned: EXMEM_Misalign=1, ByteEn=0, RegWrite=0. Valid, LdType, StType and PC are still captured so MEM can raise the trap.
- No store (StType=0): ByteEn=0, StData=rs2[31:0].
- FflagsWe = EX_FpuReady. Fflags = EX_FpuException when EX_FpuReady, else 0.
- Redirect_Valid = EX_BranchFlag. Redirect_PC = EX_BranchPC, captured on every advance.

## Timing
- Latency: one cycle, input sampled at edge N appears at outputs after edge N.
- Redirect is a single-cycle pulse per advanced instruction. It is never repeated while held under Mem_StallReq.
- An EX stall of k cycles produces exactly k bubbles; the instruction advances on the cycle EX_StallReq drops.
- flush_i together with Mem_StallReq: flush wins.
- Reset mid-operation: all outputs go to 0 immediately (async), including AluData, StData and both PCs.
- No combinational path from inputs to outputs.

## Test plan
- Reset: rst_n=1 mid-stream → all outputs 0 without a clock edge. Release, then a valid ADD with AluData=0x1234 and Rd=5 → next cycle Valid=1, AluData=0x1234, RdAddr=5, RegWrite=1.
- Store alignment: SB with addr=0x1003, rs2=0xAB → StData=0xABABABAB, ByteEn=4'b1000. SH with addr=0x1002, rs2=0xBEEF → StData=0xBEEFBEEF, ByteEn=4'b1100.
- Misalign: SW at addr=0x1001 → Misalign=1, ByteEn=0, Valid=1. LW at 0x1002 with RegWrite=1 → Misalign=1, RegWrite=0.
- Stall interplay: EX_StallReq held 3 cycles → 3 bubbles then the instruction. Mem_StallReq held 2 cycles with a branch (target 0x200) in MEM → Redirect_Valid high only in the first cycle and outputs held for 2 cycles.
- Flush priority: flush_i=1 together with Mem_StallReq=1 and a valid store → Valid=0, ByteEn=0, Redirect_Valid=0 next cycle.
- FPU flags: EX_FpuReady=1 with flags 5'b00001 → FflagsWe=1, Fflags=5'b00001 for one cycle. EX_FpuReady=0 → FflagsWe=0, Fflags=0.
